sr_cmd_debounce: RTL and testbench
==================================

Name: sr_cmd_debounce

Overview:
- Upstream command stage for the team's SR latch.
- Takes two raw, asynchronous, bouncing push-button inputs (set and reset). Synchronises and debounces them, then turns each debounced press into a fixed-width S or R pulse.
- Guarantees the latch never sees S=1 and R=1 together; the forbidden combination is reported on a status output instead.

Parameters:
- DB_CNT, 4: consecutive clk edges a synchronised input must differ from its debounced level before that level flips; legal range 2..65535.
- PULSE_LEN, 2: clk cycles that S or R is held high per accepted press; legal range 1..255.
- GUARD_LEN, 1: clk cycles with S=R=0 forced after every pulse, before the next pulse may start; legal range 1..255.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset for all state.
- set_btn_raw  input  1  raw set button, asynchronous to clk.
- rst_btn_raw  input  1  raw reset button, asynchronous to clk.
- S  output  1  registered set pulse to the SR latch.
- R  output  1  registered reset pulse to the SR latch.
- set_lvl  output  1  debounced set-button level.
- rst_lvl  output  1  debounced reset-button level.
- conflict  output  1  one-cycle pulse when set and reset requests collide.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs go to 0 immediately. This covers S, R, set_lvl, rst_lvl, conflict and busy. Synchronisers, counters, pending flags and FSM clear; FSM goes to IDLE. Reset may be asserted mid-pulse, and S/R drop without waiting for a clk edge. After release, operation resumes on the first clk edge.
- Synchroniser: each raw input passes through a 2-flop synchroniser with reset value 0.
- Debounce (per channel):
  - The counter increments on each edge where the synchronised value differs from the debounced level.
  - It clears on any edge where they match.
  - When the count reaches DB_CNT, the level flips and the counter clears on that same edge.
  - set_lvl and rst_lvl are the debounced levels.
- Request: a rising edge of a debounced level (level=1, previous level=0) raises a one-cycle request. Falling edges generate nothing.
- Pending flags:
  - A request arriving while the FSM is not in IDLE sets that channel's pending flag.
  - Flags are one deep; a second request on the same channel while pending is dropped.
  - Flags clear when consumed in IDLE.
- FSM states: IDLE, SET_PULSE, RST_PULSE, GUARD.
  - IDLE:
    - effective set = set request OR set pending; effective reset is formed the same way.
    - Set only: go to SET_PULSE.
    - Reset only: go to RST_PULSE.
    - Both: conflict=1 for one cycle, both consumed, stay in IDLE, S=R=0.
  - SET_PULSE: S=1 for exactly PULSE_LEN cycles, then GUARD.
  - RST_PULSE: R=1 for exactly PULSE_LEN cycles, then GUARD.
  - GUARD: S=R=0 for exactly GUARD_LEN cycles, then IDLE.
  - busy=1 in every state except IDLE.
- Invariant: S and R are never 1 in the same cycle, including across reset release.
- Latency: count the first clk edge that samples a raw input high as edge 1.
  - The debounced level flips at edge DB_CNT+2.
  - S (or R) rises at edge DB_CNT+3 when the FSM is IDLE.
  - With DB_CNT=4: set_lvl rises at edge 6 and S at edge 7.
- Glitch rejection: a raw pulse seen by the synchroniser for fewer than DB_CNT consecutive edges never changes the debounced level.
- Counters are wide enough for the parameter maxima and do not wrap within legal ranges.

Optional Feature:
- Macro: SR_SET_PRIORITY_EN
- Defined: when set and reset are effective in the same IDLE cycle, conflict still pulses for one cycle. The set wins: SET_PULSE is entered and both requests are consumed.
- Undefined: both requests are dropped, as described under Behaviour.

Test Plan:
- Hold set_btn_raw=1 from edge 1 (DB_CNT=4, PULSE_LEN=2, GUARD_LEN=1) -> set_lvl=1 at edge 6; S=1 at edges 7-8; S=0 and busy=1 at edge 9; busy=0 at edge 10; R stays 0 throughout.
- Bounce on rst_btn_raw: high for 3 cycles, low for 1, then held high -> no R pulse from the glitch. rst_lvl rises 4 debounce edges after the final rise; R pulses for 2 cycles.
- Both buttons rise in the same cycle and are held -> conflict=1 for exactly one cycle, S=R=0, busy=0. With SR_SET_PRIORITY_EN: conflict=1 and S pulses for 2 cycles.
- Reset request debounced while S is high -> pending set. After GUARD, R pulses for 2 cycles; no overlap with S; exactly one R pulse.
- rst_n=0 asserted while S=1, between clock edges -> S drops to 0 immediately. All outputs are 0, and there is no pulse after release unless a new press occurs.
- Randomised bouncing on both inputs for 10k cycles -> checker asserts S&R never 1; every S/R pulse is exactly PULSE_LEN cycles long; pulses are separated by at least GUARD_LEN cycles.

Source files
------------

// File: rtl/sr_cmd_debounce.sv
// sr_cmd_debounce: sync + debounce two bouncing buttons into exclusive S/R pulses for an SR latch.
// Define SR_SET_PRIORITY_EN to let set win (still flagging conflict) when both requests collide.
module sr_cmd_debounce #(
  parameter int DB_CNT    = 4,
  parameter int PULSE_LEN = 2,
  parameter int GUARD_LEN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn_raw,
  input  logic rst_btn_raw,
  output logic S,
  output logic R,
  output logic set_lvl,
  output logic rst_lvl,
  output logic conflict,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, SET_PULSE, RST_PULSE, GUARD} state_t;
`ifdef SR_SET_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic [1:0] raw, lvl, req, eff, pend_q;
  logic [7:0] ph_q;
  logic       s_q, r_q, conflict_q, busy_q;
  state_t     state_q;
  assign raw = {rst_btn_raw, set_btn_raw};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic        s1_q, s2_q, lvl_q, prev_q, lvl_d;
    logic [15:0] cnt_q, cnt_d;
    // counter restarts on every match and on the flip itself
    always_comb begin
      cnt_d = (s2_q == lvl_q || cnt_q == 16'(DB_CNT - 1)) ? '0 : cnt_q + 16'd1;
      lvl_d = (s2_q != lvl_q && cnt_q == 16'(DB_CNT - 1)) ? ~lvl_q : lvl_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= raw[c];
        s2_q   <= s1_q;
        lvl_q  <= lvl_d;
        prev_q <= lvl_q;
        cnt_q  <= cnt_d;
      end
    end
    assign lvl[c] = lvl_q;
    assign req[c] = lvl_q & ~prev_q;
  end
  assign eff = req | pend_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      pend_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      conflict_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pend_q     <= '0;
          ph_q       <= '0;
          conflict_q <= &eff;
          if (eff[0] && (!eff[1] || PRIO)) begin
            state_q <= SET_PULSE;
            s_q     <= 1'b1;
            busy_q  <= 1'b1;
          end else if (eff[1] && !eff[0]) begin
            state_q <= RST_PULSE;
            r_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SET_PULSE, RST_PULSE: begin
          pend_q <= pend_q | req;
          if (ph_q == 8'(PULSE_LEN - 1)) begin
            state_q <= GUARD;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            ph_q    <= '0;
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        GUARD: begin
          pend_q <= pend_q | req;
          if (ph_q == 8'(GUARD_LEN - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ph_q    <= '0;
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign S        = s_q;
  assign R        = r_q;
  assign set_lvl  = lvl[0];
  assign rst_lvl  = lvl[1];
  assign conflict = conflict_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_sr_cmd_debounce.sv
// tb_sr_cmd_debounce: directed and random-bounce checks of sr_cmd_debounce (DB_CNT=4, PULSE_LEN=2, GUARD_LEN=1).
module tb_sr_cmd_debounce;
  localparam int DB_CNT = 4, PULSE_LEN = 2, GUARD_LEN = 1;
  logic clk = 1'b0, rst_n = 1'b0, set_raw = 1'b0, rst_raw = 1'b0;
  logic S, R, set_lvl, rst_lvl, conflict, busy;
  logic [5:0] obs, exp_v;
  int total = 0, bad = 0;
  sr_cmd_debounce #(.DB_CNT(DB_CNT), .PULSE_LEN(PULSE_LEN), .GUARD_LEN(GUARD_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .set_btn_raw(set_raw), .rst_btn_raw(rst_raw),
    .S(S), .R(R), .set_lvl(set_lvl), .rst_lvl(rst_lvl), .conflict(conflict), .busy(busy)
  );
  always #5 clk = ~clk;
  assign obs = {S, R, set_lvl, rst_lvl, conflict, busy};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle(input string name);
    set_raw = 1'b0;
    rst_raw = 1'b0;
    repeat (14) tick();
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL %s settle: got %b want 000000", name, obs);
    end
  endtask
  task automatic test_reset();
    #12;
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL reset: got %b want 000000", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_set_press();
    set_raw = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      exp_v = {e >= 7 && e <= 8, 1'b0, e >= 6, 1'b0, 1'b0, e >= 7 && e <= 9};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL set_press edge %0d: got %b want %b", e, obs, exp_v);
      end
    end
    settle("set_press");
  endtask
  task automatic test_bounce();
    for (int e = 1; e <= 14; e++) begin
      rst_raw = !(e == 4);
      tick();
      exp_v = {1'b0, e >= 11 && e <= 12, 1'b0, e >= 10, 1'b0, e >= 11 && e <= 13};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL bounce edge %0d: got %b want %b", e, obs, exp_v);
      end
    end
    settle("bounce");
  endtask
  task automatic test_both();
    set_raw = 1'b1;
    rst_raw = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
`ifdef SR_SET_PRIORITY_EN
      exp_v = {e >= 7 && e <= 8, 1'b0, e >= 6, e >= 6, e == 7, e >= 7 && e <= 9};
`else
      exp_v = {1'b0, 1'b0, e >= 6, e >= 6, e == 7, 1'b0};
`endif
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL both edge %0d: got %b want %b", e, obs, exp_v);
      end
    end
    settle("both");
  endtask
  task automatic test_pending();
    set_raw = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      rst_raw = 1'b1;
      exp_v = {e >= 7 && e <= 8, e >= 11 && e <= 12, 1'b1 == (e >= 6), e >= 7, 1'b0,
               (e >= 7 && e <= 9) || (e >= 11 && e <= 13)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL pending edge %0d: got %b want %b", e, obs, exp_v);
      end
    end
    settle("pending");
  endtask
  task automatic test_async_reset();
    set_raw = 1'b1;
    repeat (7) tick();
    total++;
    if (S !== 1'b1) begin
      bad++;
      $display("FAIL async_reset pre: S got %b want 1", S);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL async_reset drop: got %b want 000000", obs);
    end
    set_raw = 1'b0;
    repeat (2) tick();
    #3;
    rst_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      total++;
      if (obs !== 6'b0) begin
        bad++;
        $display("FAIL async_reset post edge %0d: got %b want 000000", e, obs);
      end
    end
  endtask
  task automatic test_random();
    int s_run = 0, r_run = 0, gap = 0, pulses = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 19) == 0) set_raw = ~set_raw;
      if ($urandom_range(0, 19) == 0) rst_raw = ~rst_raw;
      tick();
      total++;
      if (S && R) begin
        bad++;
        $display("FAIL random overlap cycle %0d: S=%b R=%b want not both 1", i, S, R);
      end
      if (S) begin
        if (s_run == 0 && seen) begin
          total++;
          if (gap < GUARD_LEN) begin
            bad++;
            $display("FAIL random S gap cycle %0d: got %0d want >=%0d", i, gap, GUARD_LEN);
          end
        end
        s_run++;
      end else if (s_run != 0) begin
        total++;
        if (s_run != PULSE_LEN) begin
          bad++;
          $display("FAIL random S len cycle %0d: got %0d want %0d", i, s_run, PULSE_LEN);
        end
        s_run = 0;
        seen = 1'b1;
        gap = 0;
        pulses++;
      end
      if (R) begin
        if (r_run == 0 && seen) begin
          total++;
          if (gap < GUARD_LEN) begin
            bad++;
            $display("FAIL random R gap cycle %0d: got %0d want >=%0d", i, gap, GUARD_LEN);
          end
        end
        r_run++;
      end else if (r_run != 0) begin
        total++;
        if (r_run != PULSE_LEN) begin
          bad++;
          $display("FAIL random R len cycle %0d: got %0d want %0d", i, r_run, PULSE_LEN);
        end
        r_run = 0;
        seen = 1'b1;
        gap = 0;
        pulses++;
      end
      if (!S && !R) gap++;
    end
    total++;
    if (pulses == 0) begin
      bad++;
      $display("FAIL random activity: got %0d pulses want >0", pulses);
    end
    settle("random");
  endtask
  initial begin
    test_reset();
    test_set_press();
    test_bounce();
    test_both();
    test_pending();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
